// File: rtl/diag_spi_host.sv
// SPI initiator for the ROMulator diagnostics link: HALT, RESUME,
// READ_CONFIG and parity-checked READ_VRAM with retry.
module diag_spi_host #(
    parameter int CLK_DIV   = 4,
    parameter int CS_GAP    = 4,
    parameter int MAX_RETRY = 3
) (
    input  logic        fpga_clk,
    input  logic        fpga_reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [10:0] vram_size,
    output logic        done,
    output logic        error,
    output logic [7:0]  cfg_byte,
    output logic        out_valid,
    output logic [10:0] out_addr,
    output logic [7:0]  out_data,
    output logic        spi_clk,
    output logic        spi_select,
    output logic        spi_mosi,
    input  logic        spi_miso
);

    localparam int DW = $clog2(CLK_DIV);
    localparam int GW = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(CS_GAP - 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

    localparam logic [7:0] OP_HALT   = 8'haa;
    localparam logic [7:0] OP_RESUME = 8'h55;
    localparam logic [7:0] OP_CFG    = 8'h77;
    localparam logic [7:0] OP_VRAM   = 8'h88;
    localparam logic [7:0] PAR_ERR   = 8'h22;

    typedef enum logic [1:0] {
        E_IDLE,
        E_SHIFT,
        E_GAP
    } eng_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_CFG,
        S_GROUP,
        S_PARITY,
        S_VERDICT,
        S_FINISH
    } st_t;

    eng_t          eng_state;
    logic [DW-1:0] div_cnt;
    logic [4:0]    half_cnt;
    logic [GW-1:0] gap_cnt;
    logic [7:0]    tx_sr;
    logic [7:0]    rx_sr;
    logic          eng_start;
    logic [7:0]    eng_tx;
    logic          eng_done;

    st_t           state;
    st_t           state_nx;
    logic [1:0]    op_q;
    logic [10:0]   size_q;
    logic [10:0]   group_base;
    logic [10:0]   base_nx;
    logic [2:0]    byte_idx;
    logic [RW-1:0] retry_cnt;
    logic          match_q;
    logic          drain_on;
    logic [2:0]    drain_k;
    logic [7:0]    grp_buf [8];
    logic [7:0]    par_exp;
    logic          par_ok;
    logic [7:0]    op_byte;

    // Received byte is final on the last gap cycle; the next frame
    // may start on that same cycle so the gap is exactly CS_GAP.
    assign eng_done = (eng_state == E_GAP) && (gap_cnt == GAP_LAST);

    always_ff @(posedge fpga_clk or posedge fpga_reset) begin
        if (fpga_reset) begin
            eng_state  <= E_IDLE;
            div_cnt    <= '0;
            half_cnt   <= '0;
            gap_cnt    <= '0;
            tx_sr      <= '0;
            rx_sr      <= '0;
            spi_clk    <= 1'b0;
            spi_select <= 1'b1;
            spi_mosi   <= 1'b0;
        end else if (eng_start) begin
            eng_state  <= E_SHIFT;
            div_cnt    <= '0;
            half_cnt   <= '0;
            tx_sr      <= eng_tx;
            spi_clk    <= 1'b0;
            spi_select <= 1'b0;
            spi_mosi   <= eng_tx[7];
        end else begin
            unique case (eng_state)
                E_SHIFT: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        if (half_cnt == 5'd16) begin
                            eng_state  <= E_GAP;
                            gap_cnt    <= '0;
                            spi_clk    <= 1'b0;
                            spi_select <= 1'b1;
                            spi_mosi   <= 1'b0;
                        end else begin
                            half_cnt <= half_cnt + 5'd1;
                            if (!half_cnt[0]) begin
                                spi_clk <= 1'b1;
                                rx_sr   <= {rx_sr[6:0], spi_miso};
                            end else begin
                                spi_clk  <= 1'b0;
                                spi_mosi <= tx_sr[6];
                                tx_sr    <= {tx_sr[6:0], 1'b0};
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                E_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        eng_state <= E_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        par_exp = '0;
        for (int k = 0; k < 8; k++) begin
            par_exp[k] = ^grp_buf[k];
        end
    end

    assign par_ok  = (rx_sr == par_exp);
    assign base_nx = group_base + 11'd8;

    always_comb begin
        op_byte = OP_HALT;
        unique case (cmd_op)
            2'd0: op_byte = OP_HALT;
            2'd1: op_byte = OP_RESUME;
            2'd2: op_byte = OP_CFG;
            2'd3: op_byte = OP_VRAM;
            default: op_byte = OP_HALT;
        endcase
    end

    always_comb begin
        state_nx  = state;
        eng_start = 1'b0;
        eng_tx    = 8'h00;
        unique case (state)
            S_IDLE: begin
                if (cmd_valid) begin
                    state_nx  = S_CMD;
                    eng_start = 1'b1;
                    eng_tx    = op_byte;
                end
            end
            S_CMD: begin
                if (eng_done) begin
                    unique case (op_q)
                        2'd2: begin
                            state_nx  = S_CFG;
                            eng_start = 1'b1;
                        end
                        2'd3: begin
                            state_nx  = S_GROUP;
                            eng_start = 1'b1;
                        end
                        default: state_nx = S_FINISH;
                    endcase
                end
            end
            S_CFG: begin
                if (eng_done) begin
                    state_nx = S_FINISH;
                end
            end
            S_GROUP: begin
                if (eng_done) begin
                    state_nx  = (byte_idx == 3'd7) ? S_PARITY : S_GROUP;
                    eng_start = 1'b1;
                end
            end
            S_PARITY: begin
                if (eng_done) begin
                    state_nx  = S_VERDICT;
                    eng_start = 1'b1;
                    eng_tx    = par_ok ? 8'h00 : PAR_ERR;
                end
            end
            S_VERDICT: begin
                if (eng_done) begin
                    if (match_q ? (base_nx == size_q)
                                : (retry_cnt == RETRY_MAX)) begin
                        state_nx = S_FINISH;
                    end else begin
                        state_nx  = S_GROUP;
                        eng_start = 1'b1;
                    end
                end
            end
            S_FINISH: state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    assign cmd_ready = (state == S_IDLE);
    assign done      = (state == S_FINISH);

    always_ff @(posedge fpga_clk or posedge fpga_reset) begin
        if (fpga_reset) begin
            state      <= S_IDLE;
            op_q       <= '0;
            size_q     <= '0;
            group_base <= '0;
            byte_idx   <= '0;
            retry_cnt  <= '0;
            match_q    <= 1'b0;
            drain_on   <= 1'b0;
            drain_k    <= '0;
            error      <= 1'b0;
            cfg_byte   <= '0;
            out_valid  <= 1'b0;
            out_addr   <= '0;
            out_data   <= '0;
            for (int k = 0; k < 8; k++) begin
                grp_buf[k] <= '0;
            end
        end else begin
            state     <= state_nx;
            out_valid <= 1'b0;
            // Verified bytes drain while the VERDICT frame is on the wire.
            if (drain_on) begin
                out_valid <= 1'b1;
                out_addr  <= group_base + {8'b0, drain_k};
                out_data  <= grp_buf[drain_k];
                drain_k   <= drain_k + 3'd1;
                if (drain_k == 3'd7) begin
                    drain_on <= 1'b0;
                end
            end
            unique case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        op_q       <= cmd_op;
                        size_q     <= vram_size;
                        error      <= 1'b0;
                        group_base <= '0;
                        byte_idx   <= '0;
                        retry_cnt  <= '0;
                    end
                end
                S_CFG: begin
                    if (eng_done) begin
                        cfg_byte <= rx_sr;
                    end
                end
                S_GROUP: begin
                    if (eng_done) begin
                        grp_buf[byte_idx] <= rx_sr;
                        byte_idx          <= byte_idx + 3'd1;
                    end
                end
                S_PARITY: begin
                    if (eng_done) begin
                        match_q  <= par_ok;
                        drain_on <= par_ok;
                        drain_k  <= '0;
                    end
                end
                S_VERDICT: begin
                    if (eng_done) begin
                        if (match_q) begin
                            group_base <= base_nx;
                            retry_cnt  <= '0;
                        end else if (retry_cnt == RETRY_MAX) begin
                            error <= 1'b1;
                        end else begin
                            retry_cnt <= retry_cnt + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
